// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a valid/ready request channel
// and a valid/ready response channel, with a fixed access latency.
// Optional build macro MEM_RESPONDER_BYPASS_EN: while a response is held, the
// request channel is ready whenever the response is being consumed, which
// allows back-to-back transactions without an IDLE cycle in between.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; request channel ready
// WAIT  | request captured; counting down the access latency
// RESP  | array accessed; response held until rsp_ready_i

module mem_responder #(
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [DATA_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int DEPTH = 2 ** MEM_ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic [3:0]        cnt;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic                  accept;
  logic                  enter_resp;
  logic                  acc_we;
  logic [DATA_W-1:0]     acc_addr;
  logic [DATA_W-1:0]     acc_wdata;
  logic                  acc_oor;
  logic [MEM_ADDR_W-1:0] acc_idx;

  // Request-channel ready; held low while reset is asserted so nothing is
  // accepted (or written, for zero latency) during reset.
  always_comb begin
    req_ready_o = 1'b0;
    if (reset) begin
      case (state)
        IDLE:    req_ready_o = 1'b1;
`ifdef MEM_RESPONDER_BYPASS_EN
        RESP:    req_ready_o = rsp_ready_i;
`else
        RESP:    req_ready_o = 1'b0;
`endif
        default: req_ready_o = 1'b0;
      endcase
    end
  end

  assign accept = req_valid_i && req_ready_o;

  // Next-state logic; an accept out of RESP only happens in the bypass build.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The array is accessed on the edge that enters RESP. With zero latency
  // that is the accept edge itself, so the live request fields are used.
  always_comb begin
    enter_resp = (state == WAIT && cnt == 4'd1) || (accept && LATENCY == 0);
    acc_we     = (state == WAIT) ? we_q    : req_we_i;
    acc_addr   = (state == WAIT) ? addr_q  : req_addr_i;
    acc_wdata  = (state == WAIT) ? wdata_q : req_wdata_i;
    acc_oor    = |acc_addr[DATA_W-1:MEM_ADDR_W];
    acc_idx    = acc_addr[MEM_ADDR_W-1:0];
  end

  // State, latency counter, captured request and registered response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        cnt     <= 4'(LATENCY);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        err_q   <= acc_oor;
        rdata_q <= (acc_we || acc_oor) ? '0 : mem[acc_idx];
      end else if (state == RESP && rsp_ready_i) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  // Storage array: not reset, written only for in-range writes.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_we && !acc_oor) mem[acc_idx] <= acc_wdata;
  end

  assign rsp_valid_o = (state == RESP);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o   = rsp_valid_o ? err_q : 1'b0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with LATENCY=2 (a_*) and one with
// LATENCY=0 (b_*). Expected responses are queued when requests are accepted
// and compared when the response handshake happens.

module tb_mem_responder;

  localparam int LAT_A = 2;
`ifdef MEM_RESPONDER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clk, reset;

  logic        a_req_valid, a_req_ready, a_we, a_rsp_valid, a_rsp_ready, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_req_valid, b_req_ready, b_we, b_rsp_valid, b_rsp_ready, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  bit   a_seen;
  int   cyc;
  int   n_chk, n_pass;

  mem_responder #(.DATA_W(32), .MEM_ADDR_W(10), .LATENCY(LAT_A)) u_a (
    .clk(clk), .reset(reset),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_we),
    .req_addr_i(a_addr), .req_wdata_i(a_wdata),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
    .rsp_rdata_o(a_rdata), .rsp_err_o(a_err)
  );

  mem_responder #(.DATA_W(32), .MEM_ADDR_W(10), .LATENCY(0)) u_b (
    .clk(clk), .reset(reset),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_we),
    .req_addr_i(b_addr), .req_wdata_i(b_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_rdata_o(b_rdata), .rsp_err_o(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after edge number k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: got timeout, required handshake", nm);
  endtask

  // Call at #1 after an edge. Accept happens on the edge following a
  // sample of ready=1, i.e. edge number cyc+1.
  task automatic send_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input bit push);
    int n;
    exp_t e;
    n = 0;
    a_req_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    while (!a_req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!a_req_ready) fail_now("a_accept_timeout");
    else if (push) begin
      e.rdata = exp_rd; e.err = exp_err; e.acc = cyc + 1;
      qa.push_back(e);
    end
    @(posedge clk); #1;
    a_req_valid = 1'b0;
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while (qa.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (qa.size() != 0) fail_now("a_drain_timeout");
  endtask

  task automatic wait_valid_a();
    int n;
    n = 0;
    while (!a_rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!a_rsp_valid) fail_now("a_rsp_valid_timeout");
  endtask

  // Response monitor for instance A. A response first visible after edge k
  // is sampled by the consumer at edge k+1; that must be LATENCY+1 edges
  // after the accept edge.
  always @(negedge clk) begin
    if (reset) begin
      if (a_rsp_valid) begin
        if (qa.size() == 0) fail_now("a_unexpected_rsp");
        else begin
          if (!a_seen) begin
            chk("a_latency", 32'(cyc + 1 - qa[0].acc), 32'(LAT_A + 1));
            a_seen = 1'b1;
          end
          if (a_rsp_ready) begin
            ea = qa.pop_front();
            chk("a_rdata", a_rdata, ea.rdata);
            chk("a_err", 32'(a_err), 32'(ea.err));
            a_seen = 1'b0;
          end
        end
      end else begin
        chk("a_idle_rdata", a_rdata, 32'd0);
        chk("a_idle_err", 32'(a_err), 32'd0);
      end
    end
  end

  // Response monitor for instance B (rsp_ready held at 1 throughout).
  always @(negedge clk) begin
    if (reset && b_rsp_valid && b_rsp_ready) begin
      if (qb.size() == 0) fail_now("b_unexpected_rsp");
      else begin
        eb = qb.pop_front();
        chk("b_latency", 32'(cyc + 1 - eb.acc), 32'd1);
        chk("b_rdata", b_rdata, eb.rdata);
        chk("b_err", 32'(b_err), 32'(eb.err));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[11];
    int   n, prev_acc, acc;
    exp_t e;

    vt[0]  = '{1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0,          1'b0};
    vt[1]  = '{1'b0, 32'h0000_0005, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h0000_0000, 32'hA5A5_0000, 32'h0,          1'b0};
    vt[3]  = '{1'b0, 32'h0000_0400, 32'h0,         32'h0,          1'b1};
    vt[4]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_0000, 1'b0};
    vt[5]  = '{1'b1, 32'h0000_03FF, 32'h1234_5678, 32'h0,          1'b0};
    vt[6]  = '{1'b0, 32'h0000_03FF, 32'h0,         32'h1234_5678, 1'b0};
    vt[7]  = '{1'b1, 32'h0000_0405, 32'h0000_0BAD, 32'h0,          1'b1};
    vt[8]  = '{1'b0, 32'h0000_0005, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vt[9]  = '{1'b1, 32'h0000_0007, 32'h0000_0055, 32'h0,          1'b0};
    vt[10] = '{1'b0, 32'h0000_0007, 32'h0,         32'h0000_0055, 1'b0};

    n_chk = 0; n_pass = 0; cyc = 0; a_seen = 1'b0;
    reset = 1'b0;
    a_req_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_rsp_ready = 1'b1;

    #2;
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", a_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_req_ready", 32'(a_req_ready), 32'd1);
    chk("rst_rsp_err", 32'(a_err), 32'd0);
    @(posedge clk); #1;

    // Table-driven transactions on instance A.
    for (int i = 0; i < 11; i++)
      send_a(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_rdata, vt[i].exp_err, 1'b1);
    drain_a();

    // Held response: stable output, request channel closed, stray write ignored.
    a_rsp_ready = 1'b0;
    send_a(1'b0, 32'h5, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    wait_valid_a();
    for (int k = 0; k < 5; k++) begin
      a_req_valid = 1'b1; a_we = 1'b1; a_addr = 32'h5; a_wdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      chk("hold_valid", 32'(a_rsp_valid), 32'd1);
      chk("hold_rdata", a_rdata, 32'hDEAD_BEEF);
      chk("hold_req_ready", 32'(a_req_ready), 32'd0);
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    drain_a();
    send_a(1'b0, 32'h5, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    drain_a();

    // Instance B (LATENCY=0): write 1..4, then read them back, valid held high.
    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      b_req_valid = 1'b1;
      b_we    = (i < 4);
      b_addr  = 32'((i % 4) + 1);
      b_wdata = 32'h11 * 32'((i % 4) + 1);
      n = 0;
      while (!b_req_ready && n < 20) begin
        @(posedge clk); #1; n++;
      end
      if (!b_req_ready) fail_now("b_accept_timeout");
      else begin
        acc = cyc + 1;
        e.rdata = (i < 4) ? 32'h0 : 32'h11 * 32'((i % 4) + 1);
        e.err = 1'b0; e.acc = acc;
        qb.push_back(e);
        if (i > 0) chk("b_accept_gap", 32'(acc - prev_acc), BYP ? 32'd1 : 32'd2);
        prev_acc = acc;
      end
      @(posedge clk); #1;
    end
    b_req_valid = 1'b0;
    n = 0;
    while (qb.size() != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (qb.size() != 0) fail_now("b_drain_timeout");

    // Reset while a response is held: outputs clear without a clock edge.
    a_rsp_ready = 1'b0;
    send_a(1'b0, 32'h7, 32'h0, 32'h55, 1'b0, 1'b1);
    wait_valid_a();
    #2 reset = 1'b0;
    #1;
    chk("async_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("async_rsp_rdata", a_rdata, 32'd0);
    qa.delete();
    a_seen = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("post_rst_req_ready", 32'(a_req_ready), 32'd1);
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Reset during WAIT of a write to addr 7: write must not land.
    send_a(1'b1, 32'h7, 32'h1234, 32'h0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("wait_rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    send_a(1'b0, 32'h7, 32'h0, 32'h55, 1'b0, 1'b1);
    drain_a();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: width of data words and of the request address.
REQ-002 The block SHALL have parameter MEM_ADDR_W, default 10: word-address width, giving a depth of 2**MEM_ADDR_W words.
REQ-003 The block SHALL have parameter LATENCY, default 2, legal range 0..15: wait cycles between request accept and array access.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid_i, input, 1 bit: request present.
REQ-007 The block SHALL have port req_ready_o, output, 1 bit: request accepted when both this and req_valid_i are 1.
REQ-008 The block SHALL have port req_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr_i, input, DATA_W bits: word address.
REQ-010 The block SHALL have port req_wdata_i, input, DATA_W bits: write data.
REQ-011 The block SHALL have port rsp_valid_o, output, 1 bit: response present.
REQ-012 The block SHALL have port rsp_ready_i, input, 1 bit: response consumed when both this and rsp_valid_o are 1.
REQ-013 The block SHALL have port rsp_rdata_o, output, DATA_W bits: read data; 0 for writes and for errors.
REQ-014 The block SHALL have port rsp_err_o, output, 1 bit: address out of range.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-016 In IDLE, req_ready_o SHALL be 1; in WAIT, req_ready_o SHALL be 0; in RESP, req_ready_o SHALL be 0 unless REQ-028 applies.
REQ-017 On accept, the block SHALL register we, addr and wdata; next state SHALL be WAIT with the counter loaded to LATENCY, or RESP directly if LATENCY==0.
REQ-018 In WAIT, the counter SHALL decrement once per cycle, and the block SHALL move to RESP on the cycle the counter equals 1.
REQ-019 The array access SHALL occur on the transition into RESP, so that rsp_valid_o rises exactly LATENCY+1 cycles after the accept edge.
REQ-020 An address is out of range when any bit of addr[DATA_W-1:MEM_ADDR_W] is 1; in that case the block SHALL set rsp_err_o=1 and rsp_rdata_o=0, and SHALL NOT write the array.
REQ-021 A read SHALL return the word stored at addr[MEM_ADDR_W-1:0]; a write SHALL store wdata there and respond with rdata 0 and err 0.
REQ-022 In RESP, rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL be held stable until rsp_ready_i is 1; the block SHALL then go to IDLE (the no-bypass case).
REQ-023 rsp_valid_o SHALL be 0 outside RESP; rsp_rdata_o and rsp_err_o SHALL be 0 when rsp_valid_o is 0.
REQ-024 Request inputs SHALL be ignored whenever req_ready_o is 0.
REQ-025 A read issued after a write to the same address SHALL return the written data.

Reset
REQ-026 Asserting reset (low) SHALL immediately force IDLE, counter 0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0 and req_ready_o=1 (while reset is deasserted), and SHALL abort any in-flight request.
REQ-027 An in-flight write still in WAIT at reset SHALL NOT be committed; array contents SHALL NOT be cleared by reset (initial contents undefined).

Configuration
REQ-028 With macro MEM_RESPONDER_BYPASS_EN defined, the block SHALL drive req_ready_o=rsp_ready_i in RESP, and a handshake on both channels in the same cycle SHALL accept the new request per REQ-017 (back-to-back, one transaction per LATENCY+1 cycles); without the macro, req_ready_o SHALL be 0 in RESP and the block SHALL pass through IDLE between transactions.

Verification
REQ-029 LATENCY=2: write addr 5 data 0xDEADBEEF, then read addr 5 -> each rsp_valid_o rises 3 cycles after its accept; the read returns 0xDEADBEEF with err 0.
REQ-030 Read addr 0x400 (MEM_ADDR_W=10) -> rsp_err_o=1, rdata 0; a later read of addr 0 shows the prior contents unchanged.
REQ-031 Hold rsp_ready_i=0 for 5 cycles in RESP -> response stable, req_ready_o=0 (no bypass), and a new req_valid_i is not accepted.
REQ-032 Assert reset in WAIT during a write of 0x1234 to addr 7 (addr 7 previously 0x55) -> outputs cleared asynchronously; a subsequent read of addr 7 returns 0x55.
REQ-033 MEM_RESPONDER_BYPASS_EN, LATENCY=0: stream 4 reads with rsp_ready_i=1 -> one response per 1 cycle after the first, in order.
REQ-034 LATENCY=0 without the macro -> accept-to-rsp_valid_o is 1 cycle, and accepts occur no more often than every 2 cycles.
